// File: rtl/gpu_lmem_pkg.sv
// Shared encodings and constants for the GPU/DSP local-memory responder.
package gpu_lmem_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [1:0] MSIZE_BYTE = 2'b00;
  localparam logic [1:0] MSIZE_WORD = 2'b01;
  localparam logic [1:0] MSIZE_LONG = 2'b10;

  localparam logic [ADDR_W-1:0] GPU_LMEM_BASE = 24'hF03000;
  localparam logic [ADDR_W-1:0] DSP_LMEM_BASE = 24'hF1B000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } lmem_state_e;

endpackage

// File: rtl/gpu_lmem_lane.sv
// Big-endian lane logic: write replication / byte enables and read lane extraction.
module gpu_lmem_lane
  import gpu_lmem_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        lane_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] wdata_c,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] rdata_c
);

  // Lane 0 is the most significant byte; size 11 falls through as a long.
  always_comb begin
    wdata_c = wdata_i;
    be_c    = 4'b1111;
    rdata_c = rdata_i;
    case (size_i)
      MSIZE_BYTE: begin
        wdata_c = {4{wdata_i[7:0]}};
        be_c    = 4'b1000 >> lane_i;
        case (lane_i)
          2'd0:    rdata_c = {24'h0, rdata_i[31:24]};
          2'd1:    rdata_c = {24'h0, rdata_i[23:16]};
          2'd2:    rdata_c = {24'h0, rdata_i[15:8]};
          default: rdata_c = {24'h0, rdata_i[7:0]};
        endcase
      end
      MSIZE_WORD: begin
        wdata_c = {2{wdata_i[15:0]}};
        be_c    = lane_i[1] ? 4'b0011 : 4'b1100;
        rdata_c = lane_i[1] ? {16'h0, rdata_i[15:0]} : {16'h0, rdata_i[31:16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gpu_lmem_resp.sv
// Program/data request responder for the local SRAM; registered 4-state access FSM.
// Define LMEM_EXTSEL_EN to enable the address-window compare and ext_sel handoff.
module gpu_lmem_resp
  import gpu_lmem_pkg::*;
#(
  parameter logic [23:0] LMEM_BASE = GPU_LMEM_BASE,
  parameter int unsigned AW        = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          progreq,
  input  logic [21:0]   progaddr,
  output logic          progack,
  output logic [31:0]   prog_rdata,
  input  logic          datreq,
  input  logic [23:0]   dataddr,
  input  logic          datwe,
  input  logic [1:0]    msize,
  input  logic [31:0]   dat_wdata,
  output logic          datack,
  output logic [31:0]   dat_rdata,
  output logic          ext_sel,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  output logic [3:0]    ram_be,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [31:0]   ram_rdata
);

  lmem_state_e state_q, state_d;
  logic        last_dat_q, last_dat_d;
  logic        is_dat_q, is_dat_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;

  logic          progack_q, progack_d, datack_q, datack_d;
  logic [31:0]   prog_rdata_q, prog_rdata_d, dat_rdata_q, dat_rdata_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [3:0]    ram_be_q, ram_be_d;
  logic          ram_we_q, ram_we_d, ram_re_q, ram_re_d;

  logic [23:0] prog_byte_addr, prog_off, dat_off;
  logic        prog_ok, dat_ok, grant_dat;
  logic [1:0]  lane_size, lane_idx;
  logic [31:0] lane_wdata, lane_rdata;
  logic [3:0]  lane_be;

  assign prog_byte_addr = {progaddr, 2'b00};
  assign prog_off       = prog_byte_addr - LMEM_BASE;
  assign dat_off        = dataddr - LMEM_BASE;

`ifdef LMEM_EXTSEL_EN
  logic prog_in, dat_in, ext_sel_q, ext_sel_d;

  assign prog_in   = (prog_byte_addr[23:AW+2] == LMEM_BASE[23:AW+2]);
  assign dat_in    = (dataddr[23:AW+2] == LMEM_BASE[23:AW+2]);
  assign prog_ok   = progreq & prog_in;
  assign dat_ok    = datreq & dat_in;
  assign ext_sel_d = (progreq & ~prog_in) | (datreq & ~dat_in);

  // Out-of-window requests are flagged for the external responder, one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ext_sel_q <= 1'b0;
    else          ext_sel_q <= ext_sel_d;
  end
  assign ext_sel = ext_sel_q;
`else
  assign prog_ok = progreq;
  assign dat_ok  = datreq;
  assign ext_sel = 1'b0;
`endif

  // Data wins a tie unless it also won the previous grant.
  assign grant_dat = dat_ok & (~prog_ok | ~last_dat_q);

  // In IDLE the lane logic sees the incoming request; afterwards the latched one.
  always_comb begin
    if (state_q == IDLE) begin
      lane_size = grant_dat ? msize : MSIZE_LONG;
      lane_idx  = grant_dat ? dataddr[1:0] : 2'b00;
    end else begin
      lane_size = size_q;
      lane_idx  = lane_q;
    end
  end

  gpu_lmem_lane u_lane (
    .size_i  (lane_size),
    .lane_i  (lane_idx),
    .wdata_i (dat_wdata),
    .rdata_i (ram_rdata),
    .wdata_c (lane_wdata),
    .be_c    (lane_be),
    .rdata_c (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    last_dat_d   = last_dat_q;
    is_dat_d     = is_dat_q;
    we_d         = we_q;
    size_d       = size_q;
    lane_d       = lane_q;
    progack_d    = 1'b0;
    datack_d     = 1'b0;
    prog_rdata_d = prog_rdata_q;
    dat_rdata_d  = dat_rdata_q;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    ram_be_d     = '0;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (prog_ok | dat_ok) begin
          state_d    = ISSUE;
          is_dat_d   = grant_dat;
          last_dat_d = grant_dat;
          we_d       = grant_dat & datwe;
          size_d     = lane_size;
          lane_d     = lane_idx;
          ram_addr_d = AW'((grant_dat ? dat_off : prog_off) >> 2);
          if (grant_dat & datwe) begin
            ram_we_d    = 1'b1;
            ram_wdata_d = lane_wdata;
            ram_be_d    = lane_be;
          end else begin
            ram_re_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d  = ACK;
          datack_d = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        state_d = ACK;
        if (is_dat_q) begin
          datack_d    = 1'b1;
          dat_rdata_d = lane_rdata;
        end else begin
          progack_d    = 1'b1;
          prog_rdata_d = lane_rdata;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_dat_q   <= 1'b0;
      is_dat_q     <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      progack_q    <= 1'b0;
      datack_q     <= 1'b0;
      prog_rdata_q <= '0;
      dat_rdata_q  <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_be_q     <= '0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dat_q   <= last_dat_d;
      is_dat_q     <= is_dat_d;
      we_q         <= we_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      progack_q    <= progack_d;
      datack_q     <= datack_d;
      prog_rdata_q <= prog_rdata_d;
      dat_rdata_q  <= dat_rdata_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_be_q     <= ram_be_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
    end
  end

  assign progack    = progack_q;
  assign datack     = datack_q;
  assign prog_rdata = prog_rdata_q;
  assign dat_rdata  = dat_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_be     = ram_be_q;
  assign ram_we     = ram_we_q;
  assign ram_re     = ram_re_q;

endmodule

// File: tb/tb_gpu_lmem_resp.sv
// Scoreboard bench for gpu_lmem_resp against a byte-array big-endian memory model.
module tb_gpu_lmem_resp;
  import gpu_lmem_pkg::*;

  localparam logic [23:0] BASE = GPU_LMEM_BASE;
  localparam int unsigned AW   = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          progreq, datreq, datwe;
  logic [21:0]   progaddr;
  logic [23:0]   dataddr;
  logic [1:0]    msize;
  logic [31:0]   dat_wdata;
  logic          progack, datack, ext_sel, ram_we, ram_re;
  logic [31:0]   prog_rdata, dat_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;

  always #5 clk = ~clk;

  gpu_lmem_resp #(.LMEM_BASE(BASE), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .progreq(progreq), .progaddr(progaddr), .progack(progack), .prog_rdata(prog_rdata),
    .datreq(datreq), .dataddr(dataddr), .datwe(datwe), .msize(msize), .dat_wdata(dat_wdata),
    .datack(datack), .dat_rdata(dat_rdata), .ext_sel(ext_sel),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  // SRAM macro stand-in: one-cycle read latency, per-byte write enables.
  logic [31:0] ram_m [1024];
  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_m[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    if (ram_re) ram_rdata <= ram_m[ram_addr];
  end

  // Reference: flat byte array, byte offset 0 of a long is its MSB.
  logic [7:0]  mem_b [4096];
  logic [32:0] dat_q [$];
  logic [32:0] prog_q [$];
  logic [32:0] me;
  int n_chk = 0, n_pass = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned moff(logic [23:0] a);
    return 32'((a - BASE) & 24'hFFF);
  endfunction

  function automatic logic [31:0] mdl_read(logic [23:0] a, logic [1:0] sz);
    int unsigned o = moff(a);
    if (sz == MSIZE_BYTE) return {24'h0, mem_b[o]};
    if (sz == MSIZE_WORD) begin
      o = o & ~32'd1;
      return {16'h0, mem_b[o], mem_b[o+1]};
    end
    o = o & ~32'd3;
    return {mem_b[o], mem_b[o+1], mem_b[o+2], mem_b[o+3]};
  endfunction

  task automatic mdl_write(logic [23:0] a, logic [1:0] sz, logic [31:0] wd);
    int unsigned o = moff(a);
    if (sz == MSIZE_BYTE) mem_b[o] = wd[7:0];
    else if (sz == MSIZE_WORD) begin
      o = o & ~32'd1;
      mem_b[o] = wd[15:8]; mem_b[o+1] = wd[7:0];
    end else begin
      o = o & ~32'd3;
      mem_b[o] = wd[31:24]; mem_b[o+1] = wd[23:16]; mem_b[o+2] = wd[15:8]; mem_b[o+3] = wd[7:0];
    end
  endtask

  function automatic logic [3:0] exp_be(logic [23:0] a, logic [1:0] sz);
    int unsigned o = moff(a) % 4;
    if (sz == MSIZE_BYTE) return 4'(8 >> o);
    if (sz == MSIZE_WORD) return (o >= 2) ? 4'b0011 : 4'b1100;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_rep(logic [31:0] wd, logic [1:0] sz);
    if (sz == MSIZE_BYTE) return {4{wd[7:0]}};
    if (sz == MSIZE_WORD) return {2{wd[15:0]}};
    return wd;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail_bound(string nm);
    n_chk++;
    $display("FAIL %s: got no ack expected ack within bound (cycle %0d)", nm, cyc);
  endtask

  // Monitor: every ack pops its port's queue; reads compare data.
  always @(posedge clk) begin
    #1;
    if (datack) begin
      if (dat_q.size() == 0) fail_bound("datack_unexpected");
      else begin
        me = dat_q.pop_front();
        if (me[32]) chk("dat_rdata", dat_rdata, me[31:0]);
      end
    end
    if (progack) begin
      if (prog_q.size() == 0) fail_bound("progack_unexpected");
      else begin
        me = prog_q.pop_front();
        chk("prog_rdata", prog_rdata, me[31:0]);
      end
    end
  end

  task automatic dat_txn(bit we, logic [1:0] sz, logic [23:0] a, logic [31:0] wd);
    int lat = 1;
    datreq = 1'b1; datwe = we; msize = sz; dataddr = a; dat_wdata = wd;
    @(posedge clk); #1;
    chk("ram_we", 32'(ram_we), 32'(we));
    chk("ram_re", 32'(ram_re), 32'(!we));
    chk("ram_addr", 32'(ram_addr), 32'(moff(a) >> 2));
    if (we) begin
      chk("ram_be", 32'(ram_be), 32'(exp_be(a, sz)));
      chk("ram_wdata", ram_wdata, exp_rep(wd, sz));
      mdl_write(a, sz, wd);
      dat_q.push_back({1'b0, 32'h0});
    end else begin
      dat_q.push_back({1'b1, mdl_read(a, sz)});
    end
    while (!datack && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    if (datack) chk("dat_latency", 32'(lat), we ? 32'd2 : 32'd3);
    else fail_bound("dat_ack_timeout");
    @(posedge clk); #1;
    datreq = 1'b0;
  endtask

  task automatic prog_txn(logic [21:0] pa);
    int lat = 1;
    progreq = 1'b1; progaddr = pa;
    @(posedge clk); #1;
    chk("prog_ram_re", 32'({ram_re, ram_we}), 32'd2);
    chk("prog_ram_addr", 32'(ram_addr), 32'(moff({pa, 2'b00}) >> 2));
    prog_q.push_back({1'b1, mdl_read({pa, 2'b00}, MSIZE_LONG)});
    while (!progack && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    if (progack) chk("prog_latency", 32'(lat), 32'd3);
    else fail_bound("prog_ack_timeout");
    @(posedge clk); #1;
    progreq = 1'b0;
  endtask

  task automatic await_ack(bit is_dat, output int at);
    int n = 0;
    while (!(is_dat ? datack : progack) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (is_dat ? datack : progack) at = cyc;
    else begin
      at = -100;
      fail_bound(is_dat ? "tie_dat_timeout" : "tie_prog_timeout");
    end
    @(posedge clk); #1;
    if (is_dat) datreq = 1'b0;
    else        progreq = 1'b0;
  endtask

  task automatic tie(logic [23:0] da, logic [21:0] pa, bit dat_first);
    int dat_at, prog_at;
    datreq = 1'b1; datwe = 1'b0; msize = MSIZE_LONG; dataddr = da;
    progreq = 1'b1; progaddr = pa;
    dat_q.push_back({1'b1, mdl_read(da, MSIZE_LONG)});
    prog_q.push_back({1'b1, mdl_read({pa, 2'b00}, MSIZE_LONG)});
    fork
      await_ack(1'b1, dat_at);
      await_ack(1'b0, prog_at);
    join
    if (dat_first) chk("tie_dat_first", 32'(prog_at - dat_at), 32'd4);
    else           chk("tie_prog_first", 32'(dat_at - prog_at), 32'd4);
  endtask

  logic [23:0] ra;
  logic [31:0] rv;
  int          hits;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      rv = $urandom;
      ram_m[i] = rv;
      mem_b[4*i] = rv[31:24]; mem_b[4*i+1] = rv[23:16];
      mem_b[4*i+2] = rv[15:8]; mem_b[4*i+3] = rv[7:0];
    end
    reset_n = 1'b0; progreq = 1'b0; datreq = 1'b0; datwe = 1'b0;
    progaddr = '0; dataddr = '0; msize = '0; dat_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({progack, datack, ram_we, ram_re, ext_sel}), 32'd0);
    chk("rst_data", prog_rdata | dat_rdata | ram_wdata, 32'd0);
    chk("rst_ram", 32'({ram_addr, ram_be}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Tie from reset: data first; after a data grant, program first.
    tie(24'hF03020, 22'h3C0C00, 1'b1);
    dat_txn(1'b1, MSIZE_LONG, 24'hF03024, 32'hCAFE0001);
    tie(24'hF03024, 22'h3C0C00, 1'b0);

    dat_txn(1'b1, MSIZE_LONG, 24'hF03010, 32'h12345678);
    dat_txn(1'b0, MSIZE_LONG, 24'hF03010, 32'h0);
    chk("long_rd", dat_rdata, 32'h12345678);
    dat_txn(1'b0, MSIZE_BYTE, 24'hF03011, 32'h0);
    chk("byte_rd", dat_rdata, 32'h00000034);
    dat_txn(1'b1, MSIZE_WORD, 24'hF03012, 32'h0000BEEF);
    dat_txn(1'b0, MSIZE_LONG, 24'hF03010, 32'h0);
    chk("word_merge", dat_rdata, 32'h1234BEEF);

`ifdef LMEM_EXTSEL_EN
    datreq = 1'b1; datwe = 1'b0; msize = MSIZE_LONG; dataddr = 24'hF02000;
    @(posedge clk); #1;
    chk("ext_sel_on", 32'(ext_sel), 32'd1);
    hits = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ram_re || datack || !ext_sel) hits++;
    end
    chk("ext_quiet", 32'(hits), 32'd0);
    datreq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ext_sel_off", 32'(ext_sel), 32'd0);
`else
    dat_txn(1'b0, MSIZE_LONG, 24'hF02000, 32'h0);
    chk("alias_ext_sel", 32'(ext_sel), 32'd0);
`endif

    repeat (80) begin
      ra = BASE + 24'($urandom_range(0, 4095));
      if ($urandom_range(0, 4) == 0) prog_txn(ra[23:2]);
      else dat_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra, $urandom);
    end

    // Reset in WAIT of a read drops everything immediately.
    dat_txn(1'b1, MSIZE_LONG, 24'hF03040, 32'hA5A50001);
    dat_txn(1'b0, MSIZE_LONG, 24'hF03040, 32'h0);
    datreq = 1'b1; datwe = 1'b0; msize = MSIZE_LONG; dataddr = 24'hF03044;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ctl", 32'({ram_re, datack, ram_we}), 32'd0);
    chk("midrst_rdata", dat_rdata, 32'd0);
    datreq = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    dat_txn(1'b0, MSIZE_LONG, 24'hF03040, 32'h0);
    chk("post_rst_rd", dat_rdata, 32'hA5A50001);

    repeat (3) @(posedge clk);
    #1;
    chk("dat_q_drained", 32'(dat_q.size()), 32'd0);
    chk("prog_q_drained", 32'(prog_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
